// File: rtl/address_gen_unit.sv
// ============================================================================
// address_gen_unit : base+offset address generator with sequential burst issue
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module address_gen_unit #(
  parameter int XLEN      = 32,
  parameter int MAX_BEATS = 8,
  localparam int BW       = $clog2(MAX_BEATS) + 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            write,
  input  logic            use_pc,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] program_counter,
  input  logic [XLEN-1:0] immediate,
  input  logic [1:0]      size,
  input  logic [BW-1:0]   beats,
  input  logic            advance,
  output logic            ready,
  output logic            valid,
  output logic [XLEN-1:0] result,
  output logic [BW-1:0]   beat_index,
  output logic            last,
  output logic            misaligned
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ISSUE = 1'b1;

  logic [0:0]      state, next_state;
  logic [XLEN-1:0] addr_r;
  logic [1:0]      size_r;
  logic [BW-1:0]   last_idx_r;
  logic [BW-1:0]   idx_r;

  logic [BW-1:0]   eff_m1;
  logic [XLEN-1:0] stride;
  logic            mis_w;
  logic            last_w;

  // Burst length normalised to 1..MAX_BEATS, stored as final index.
  always_comb begin
    eff_m1 = '0;
    if (beats == '0)
      eff_m1 = '0;
    else if (beats > BW'(MAX_BEATS))
      eff_m1 = BW'(MAX_BEATS - 1);
    else
      eff_m1 = beats - BW'(1);
  end

  // Reserved size 3 steps like a word; it always aborts after one beat anyway.
  assign stride = (size_r == 2'd3) ? XLEN'(4) : (XLEN'(1) << size_r);

  assign mis_w  = (state == ISSUE) &&
                  (((size_r == 2'd1) && addr_r[0]) ||
                   ((size_r == 2'd2) && (addr_r[1:0] != 2'b00)) ||
                   (size_r == 2'd3));
  assign last_w = (state == ISSUE) && ((idx_r == last_idx_r) || mis_w);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (write) next_state = ISSUE;
      ISSUE:   if (advance && last_w) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    ready      = (state == IDLE);
    valid      = (state == ISSUE);
    result     = addr_r;
    beat_index = idx_r;
    last       = last_w;
    misaligned = mis_w;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_r     <= '0;
      size_r     <= '0;
      last_idx_r <= '0;
      idx_r      <= '0;
    end else if (state == IDLE) begin
      if (write) begin
        addr_r     <= (use_pc ? program_counter : a) + immediate;
        size_r     <= size;
        last_idx_r <= eff_m1;
        idx_r      <= '0;
      end
    end else if (advance) begin
      // Returning to idle clears the address so it reads as in reset.
      if (last_w) begin
        addr_r <= '0;
        idx_r  <= '0;
      end else begin
        addr_r <= addr_r + stride;
        idx_r  <= idx_r + BW'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_address_gen_unit.sv
// ============================================================================
// tb_address_gen_unit : scoreboard bench with directed and random bursts
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_address_gen_unit;

  localparam int XLEN      = 32;
  localparam int MAX_BEATS = 8;
  localparam int BW        = $clog2(MAX_BEATS) + 1;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            write = 1'b0;
  logic            use_pc = 1'b0;
  logic [XLEN-1:0] a = '0;
  logic [XLEN-1:0] program_counter = '0;
  logic [XLEN-1:0] immediate = '0;
  logic [1:0]      size = '0;
  logic [BW-1:0]   beats = '0;
  logic            advance = 1'b0;
  logic            ready, valid, last, misaligned;
  logic [XLEN-1:0] result;
  logic [BW-1:0]   beat_index;

  address_gen_unit #(.XLEN(XLEN), .MAX_BEATS(MAX_BEATS)) dut (
    .clock(clock), .reset(reset), .write(write), .use_pc(use_pc), .a(a),
    .program_counter(program_counter), .immediate(immediate), .size(size),
    .beats(beats), .advance(advance), .ready(ready), .valid(valid),
    .result(result), .beat_index(beat_index), .last(last), .misaligned(misaligned)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [BW-1:0]   idx;
    logic            lst;
    logic            mis;
  } beat_t;

  beat_t q[$];
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: list every beat the request should produce.
  task automatic model_push(input logic pc_sel, input logic [XLEN-1:0] av,
                            input logic [XLEN-1:0] pcv, input logic [XLEN-1:0] imm,
                            input logic [1:0] sz, input int bt);
    longint unsigned modulus = 64'd1 << XLEN;
    longint unsigned addr;
    int n;
    int step;
    bit mis;
    beat_t b;
    n    = (bt == 0) ? 1 : ((bt > MAX_BEATS) ? MAX_BEATS : bt);
    step = (sz == 2'd0) ? 1 : ((sz == 2'd1) ? 2 : 4);
    addr = ((pc_sel ? longint'(pcv) : longint'(av)) + longint'(imm)) % modulus;
    for (int i = 0; i < n; i++) begin
      mis = (sz == 2'd3) || (sz == 2'd1 && (addr % 2) != 0) || (sz == 2'd2 && (addr % 4) != 0);
      b.addr = XLEN'(addr);
      b.idx  = BW'(i);
      b.lst  = mis || (i == n - 1);
      b.mis  = mis;
      q.push_back(b);
      if (mis) break;
      addr = (addr + longint'(step)) % modulus;
    end
  endtask

  // Monitor: compare every presented beat against the scoreboard head.
  always @(negedge clock) begin
    if (!reset) begin
      check("ready_vs_valid", {63'd0, ready}, {63'd0, ~valid});
      if (valid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got result %0h expected no beat", result);
        end else begin
          check("result", {32'd0, result}, {32'd0, q[0].addr});
          check("beat_index", {{(64-BW){1'b0}}, beat_index}, {{(64-BW){1'b0}}, q[0].idx});
          check("last", {63'd0, last}, {63'd0, q[0].lst});
          check("misaligned", {63'd0, misaligned}, {63'd0, q[0].mis});
          if (advance) void'(q.pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic pc_sel, input logic [XLEN-1:0] av, input logic [XLEN-1:0] pcv,
                       input logic [XLEN-1:0] imm, input logic [1:0] sz, input int bt);
    step();
    use_pc = pc_sel; a = av; program_counter = pcv; immediate = imm;
    size = sz; beats = BW'(bt); write = 1'b1; advance = 1'b0;
    check("ready_at_write", {63'd0, ready}, 64'd1);
    if (ready) model_push(pc_sel, av, pcv, imm, sz, bt);
    step();
    write = 1'b0;
  endtask

  // Run until the scoreboard empties and the unit is idle; rnd selects random advance.
  task automatic drain(input bit rnd, input bit noise);
    int budget = 300;
    while ((q.size() != 0 || !ready) && budget > 0) begin
      advance = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      write   = noise && valid ? 1'($urandom_range(0, 1)) : 1'b0;
      if (write) begin
        a = $urandom; immediate = $urandom; beats = BW'($urandom_range(0, 15));
      end
      step();
      budget--;
    end
    write = 1'b0;
    advance = 1'b0;
    if (budget == 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d beats pending expected 0", q.size());
    end
  endtask

  initial begin
    logic [XLEN-1:0] ra;
    logic [1:0]      rs;
    #12;
    check("rst_ready", {63'd0, ready}, 64'd1);
    check("rst_valid", {63'd0, valid}, 64'd0);
    check("rst_result", {32'd0, result}, 64'd0);
    check("rst_beat_index", {{(64-BW){1'b0}}, beat_index}, 64'd0);
    check("rst_last", {63'd0, last}, 64'd0);
    check("rst_misaligned", {63'd0, misaligned}, 64'd0);
    reset = 1'b0;

    // Single access with negative offset.
    issue(1'b0, 32'h1000, 32'h0, 32'hFFFF_FFFC, 2'd2, 1);
    check("single_result", {32'd0, result}, 64'h0000_0FFC);
    drain(1'b0, 1'b0);
    check("single_idle", {63'd0, ready}, 64'd1);

    // PC-relative burst with stall at beat 1 and ignored writes.
    issue(1'b1, 32'h0, 32'h200, 32'h10, 2'd2, 4);
    advance = 1'b1;
    step();
    advance = 1'b0;
    for (int i = 0; i < 3; i++) begin
      write = 1'b1; a = 32'hDEAD_0000;
      step();
    end
    write = 1'b0;
    check("stall_result", {32'd0, result}, 64'h214);
    drain(1'b0, 1'b0);

    // Misalignment aborts.
    issue(1'b0, 32'h101, 32'h0, 32'h0, 2'd1, 4);
    drain(1'b0, 1'b0);
    issue(1'b0, 32'h100, 32'h0, 32'h0, 2'd3, 4);
    drain(1'b0, 1'b0);

    // Wrap-around with clamped length.
    issue(1'b0, 32'hFFFF_FFFC, 32'h0, 32'h0, 2'd2, 15);
    drain(1'b0, 1'b0);

    // Asynchronous reset at beat 2.
    issue(1'b0, 32'hFFFF_FFFC, 32'h0, 32'h0, 2'd2, 8);
    advance = 1'b1;
    step();
    step();
    #2;
    reset = 1'b1;
    #1;
    check("arst_valid", {63'd0, valid}, 64'd0);
    check("arst_ready", {63'd0, ready}, 64'd1);
    check("arst_result", {32'd0, result}, 64'd0);
    check("arst_beat_index", {{(64-BW){1'b0}}, beat_index}, 64'd0);
    q.delete();
    #1;
    reset = 1'b0;
    advance = 1'b0;
    issue(1'b0, 32'h1000, 32'h0, 32'hFFFF_FFFC, 2'd2, 1);
    check("post_rst_result", {32'd0, result}, 64'h0000_0FFC);
    drain(1'b0, 1'b0);

    // Random bursts with random back-pressure and writes while busy.
    for (int n = 0; n < 40; n++) begin
      rs = 2'($urandom_range(0, 3));
      ra = $urandom;
      if ($urandom_range(0, 3) != 0) ra[1:0] = 2'b00;
      issue(1'($urandom_range(0, 1)), ra, $urandom & 32'hFFFF_FFFC,
            ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFF0 : 32'($urandom_range(0, 64)) & 32'hFFFF_FFFC,
            rs, $urandom_range(0, 15));
      drain(1'b1, 1'b1);
    end

    step();
    check("final_idle", {63'd0, ready}, 64'd1);
    check("final_queue", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
